// File: rtl/eei_host_sequencer.sv
// Host-side sequencer for the RV32IMF core EEI port: turns host word commands into
// memory, register-file and run/abort sequences, returning one response per command.
module eei_host_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter int unsigned CNT_W          = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [31:0]      cmd_addr,
    input  logic [31:0]      cmd_data,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_data,
    output logic [2:0]       rsp_status,
    output logic             pm_sel,
    output logic             pm_valid,
    output logic             pm_rw,
    output logic [31:0]      pm_addr,
    output logic [31:0]      pm_wdata,
    input  logic             pm_ready,
    input  logic             pm_oor,
    input  logic [31:0]      pm_rdata,
    output logic             dm_sel,
    output logic             dm_valid,
    output logic             dm_rw,
    output logic [31:0]      dm_addr,
    output logic [31:0]      dm_wdata,
    input  logic             dm_ready,
    input  logic             dm_oor,
    input  logic [31:0]      dm_rdata,
    output logic             rf_sel,
    output logic [4:0]       rf_rs1_add,
    output logic             rf_rs1_fp,
    output logic [4:0]       rf_wb_add,
    output logic             rf_wb_fp,
    output logic [31:0]      rf_wb_data,
    output logic             rf_do_wb,
    input  logic [31:0]      rf_rs1_data,
    output logic             core_start,
    output logic             core_rst,
    output logic [31:0]      core_init_pc,
    input  logic             core_ready,
    input  logic [1:0]       core_exit,
    input  logic [31:0]      core_pc,
    output logic [CNT_W-1:0] run_cycles
);

    localparam logic [2:0] OP_RRD = 3'd4;
    localparam logic [2:0] OP_RWR = 3'd5;
    localparam logic [2:0] OP_RUN = 3'd6;
    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic             TIMEOUT_EN  = (TIMEOUT_CYCLES != 32'd0);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_MEM      = 3'd1,
        S_RREAD    = 3'd2,
        S_RWRITE   = 3'd3,
        S_RUN_WAIT = 3'd4,
        S_ABORT    = 3'd5,
        S_RESP     = 3'd6
    } state_t;

    state_t           state_r;
    state_t           state_next_s;
    logic [2:0]       op_r;
    logic [31:0]      addr_r;
    logic [31:0]      data_r;
    logic             rread_phase_r;
    logic [31:0]      rsp_data_r;
    logic [2:0]       rsp_status_r;
    logic [CNT_W-1:0] run_cycles_r;

    logic             mem_pm_s;
    logic             mem_wr_s;
    logic             mem_ready_s;
    logic             mem_oor_s;
    logic [31:0]      mem_rdata_s;
    logic             timeout_s;
    logic             wb_x0_s;

    // Ops 0/1 address program memory, 2/3 data memory; even ops are writes.
    assign mem_pm_s    = (op_r[2:1] == 2'b00);
    assign mem_wr_s    = ~op_r[0];
    assign mem_ready_s = mem_pm_s ? pm_ready : dm_ready;
    assign mem_oor_s   = mem_pm_s ? pm_oor   : dm_oor;
    assign mem_rdata_s = mem_pm_s ? pm_rdata : dm_rdata;
    assign timeout_s   = TIMEOUT_EN && (run_cycles_r == TIMEOUT_VAL);
    assign wb_x0_s     = ~addr_r[5] & (addr_r[4:0] == 5'd0);

    assign rsp_data   = rsp_data_r;
    assign rsp_status = rsp_status_r;
    assign run_cycles = run_cycles_r;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; a core_ready seen together with the timeout wins
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (cmd_valid) begin
                    case (cmd_op)
                        3'd0, 3'd1, 3'd2, 3'd3: state_next_s = S_MEM;
                        OP_RRD:                 state_next_s = S_RREAD;
                        OP_RWR:                 state_next_s = S_RWRITE;
                        OP_RUN:                 state_next_s = S_RUN_WAIT;
                        default:                state_next_s = S_RESP;
                    endcase
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_MEM: begin
                if (mem_ready_s || mem_oor_s) begin
                    state_next_s = S_RESP;
                end else begin
                    state_next_s = S_MEM;
                end
            end
            S_RREAD: begin
                if (rread_phase_r) begin
                    state_next_s = S_RESP;
                end else begin
                    state_next_s = S_RREAD;
                end
            end
            S_RWRITE: state_next_s = S_RESP;
            S_RUN_WAIT: begin
                if (core_ready) begin
                    state_next_s = S_RESP;
                end else if (timeout_s) begin
                    state_next_s = S_ABORT;
                end else begin
                    state_next_s = S_RUN_WAIT;
                end
            end
            S_ABORT: state_next_s = S_RESP;
            S_RESP: begin
                if (rsp_ready) begin
                    state_next_s = S_IDLE;
                end else begin
                    state_next_s = S_RESP;
                end
            end
            default: state_next_s = S_IDLE;
        endcase
    end

    // Command latch, response capture and run-cycle counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_r          <= 3'd0;
            addr_r        <= 32'd0;
            data_r        <= 32'd0;
            rread_phase_r <= 1'b0;
            rsp_data_r    <= 32'd0;
            rsp_status_r  <= 3'b000;
            run_cycles_r  <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (cmd_valid) begin
                        op_r          <= cmd_op;
                        addr_r        <= cmd_addr;
                        data_r        <= cmd_data;
                        rread_phase_r <= 1'b0;
                        if (cmd_op == OP_RUN) begin
                            run_cycles_r <= {CNT_W{1'b0}};
                        end
                        if (cmd_op == 3'd7) begin
                            rsp_data_r   <= 32'd0;
                            rsp_status_r <= 3'b010;
                        end
                    end
                end
                S_MEM: begin
                    if (mem_oor_s) begin
                        rsp_data_r   <= 32'd0;
                        rsp_status_r <= 3'b001;
                    end else if (mem_ready_s) begin
                        rsp_data_r   <= mem_wr_s ? 32'd0 : mem_rdata_s;
                        rsp_status_r <= 3'b000;
                    end
                end
                S_RREAD: begin
                    rread_phase_r <= 1'b1;
                    if (rread_phase_r) begin
                        rsp_data_r   <= rf_rs1_data;
                        rsp_status_r <= 3'b000;
                    end
                end
                S_RWRITE: begin
                    rsp_data_r   <= 32'd0;
                    rsp_status_r <= 3'b000;
                end
                S_RUN_WAIT: begin
                    if (core_ready) begin
                        rsp_data_r   <= core_pc;
                        rsp_status_r <= {1'b1, core_exit};
                    end else if (!timeout_s && (run_cycles_r != CNT_MAX)) begin
                        run_cycles_r <= run_cycles_r + CNT_ONE;
                    end
                end
                S_ABORT: begin
                    rsp_data_r   <= core_pc;
                    rsp_status_r <= 3'b011;
                end
                default: begin
                end
            endcase
        end
    end

    // Output decode; the core owns its buses whenever no *_sel is raised
    always_comb begin
        cmd_ready    = 1'b0;
        rsp_valid    = 1'b0;
        pm_sel       = 1'b0;
        pm_valid     = 1'b0;
        pm_rw        = 1'b0;
        pm_addr      = 32'd0;
        pm_wdata     = 32'd0;
        dm_sel       = 1'b0;
        dm_valid     = 1'b0;
        dm_rw        = 1'b0;
        dm_addr      = 32'd0;
        dm_wdata     = 32'd0;
        rf_sel       = 1'b0;
        rf_rs1_add   = 5'd0;
        rf_rs1_fp    = 1'b0;
        rf_wb_add    = 5'd0;
        rf_wb_fp     = 1'b0;
        rf_wb_data   = 32'd0;
        rf_do_wb     = 1'b0;
        core_start   = 1'b0;
        core_rst     = 1'b0;
        core_init_pc = 32'd0;
        case (state_r)
            S_IDLE: cmd_ready = 1'b1;
            S_MEM: begin
                if (mem_pm_s) begin
                    pm_sel   = 1'b1;
                    pm_valid = 1'b1;
                    pm_rw    = mem_wr_s;
                    pm_addr  = addr_r;
                    pm_wdata = data_r;
                end else begin
                    dm_sel   = 1'b1;
                    dm_valid = 1'b1;
                    dm_rw    = mem_wr_s;
                    dm_addr  = addr_r;
                    dm_wdata = data_r;
                end
            end
            S_RREAD: begin
                rf_sel     = 1'b1;
                rf_rs1_add = addr_r[4:0];
                rf_rs1_fp  = addr_r[5];
            end
            S_RWRITE: begin
                rf_sel     = 1'b1;
                rf_wb_add  = addr_r[4:0];
                rf_wb_fp   = addr_r[5];
                rf_wb_data = data_r;
                rf_do_wb   = ~wb_x0_s;
            end
            S_RUN_WAIT: begin
                core_start   = 1'b1;
                core_init_pc = data_r;
            end
            S_ABORT: core_rst = 1'b1;
            S_RESP: rsp_valid = 1'b1;
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_eei_host_sequencer.sv
// Bench for eei_host_sequencer: behavioural memories, register file and a tiny core model,
// table-driven commands checked through a response scoreboard, plus multi-cycle corner sequences.
module tb_eei_host_sequencer;

    localparam logic [31:0] ADDI_A0_7 = 32'h0070_0513;
    localparam logic [31:0] ECALL     = 32'h0000_0073;
    localparam logic [31:0] EBREAK    = 32'h0010_0073;
    localparam logic [31:0] JAL_SELF  = 32'h0000_006F;
    localparam logic [31:0] MEM_BYTES = 32'h0000_0400;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_op = 3'd0;
    logic [31:0] cmd_addr = 32'd0;
    logic [31:0] cmd_data = 32'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_data;
    logic [2:0]  rsp_status;
    logic        pm_sel, pm_valid, pm_rw, dm_sel, dm_valid, dm_rw;
    logic [31:0] pm_addr, pm_wdata, dm_addr, dm_wdata;
    logic        pm_ready = 1'b0, pm_oor = 1'b0, dm_ready = 1'b0, dm_oor = 1'b0;
    logic [31:0] pm_rdata = 32'd0, dm_rdata = 32'd0;
    logic        rf_sel, rf_rs1_fp, rf_wb_fp, rf_do_wb;
    logic [4:0]  rf_rs1_add, rf_wb_add;
    logic [31:0] rf_wb_data, rf_rs1_data;
    logic        core_start, core_rst;
    logic [31:0] core_init_pc;
    logic        core_ready = 1'b0;
    logic [1:0]  core_exit = 2'b00;
    logic [31:0] core_pc = 32'd0;
    logic [31:0] run_cycles;

    eei_host_sequencer #(.TIMEOUT_CYCLES(100), .CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_status(rsp_status),
        .pm_sel(pm_sel), .pm_valid(pm_valid), .pm_rw(pm_rw), .pm_addr(pm_addr), .pm_wdata(pm_wdata),
        .pm_ready(pm_ready), .pm_oor(pm_oor), .pm_rdata(pm_rdata),
        .dm_sel(dm_sel), .dm_valid(dm_valid), .dm_rw(dm_rw), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_ready(dm_ready), .dm_oor(dm_oor), .dm_rdata(dm_rdata),
        .rf_sel(rf_sel), .rf_rs1_add(rf_rs1_add), .rf_rs1_fp(rf_rs1_fp),
        .rf_wb_add(rf_wb_add), .rf_wb_fp(rf_wb_fp), .rf_wb_data(rf_wb_data),
        .rf_do_wb(rf_do_wb), .rf_rs1_data(rf_rs1_data),
        .core_start(core_start), .core_rst(core_rst), .core_init_pc(core_init_pc),
        .core_ready(core_ready), .core_exit(core_exit), .core_pc(core_pc),
        .run_cycles(run_cycles)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural environment ----------------
    logic [31:0] pm_mem [256] = '{default: 32'h0};
    logic [31:0] dm_mem [256] = '{default: 32'h0};
    logic [31:0] int_rf [32]  = '{default: 32'h0};
    logic [31:0] fp_rf  [32]  = '{default: 32'h0};
    int          mem_lat = 0;
    int          pm_wait = 0, dm_wait = 0;
    int          fin_cnt = 5;
    int          run_cnt = 0;
    logic        running = 1'b0;
    logic [31:0] prog_word = 32'h0;
    int          x0_wb_cnt = 0;

    // x0 is deliberately stored like any register so a stray x0 write is visible on readback
    assign rf_rs1_data = rf_rs1_fp ? fp_rf[rf_rs1_add] : int_rf[rf_rs1_add];

    always @(posedge clk) begin
        pm_ready <= 1'b0;
        pm_oor   <= 1'b0;
        if (pm_valid && !pm_ready && !pm_oor) begin
            if (pm_wait >= mem_lat) begin
                pm_wait <= 0;
                if (pm_addr >= MEM_BYTES) pm_oor <= 1'b1;
                else begin
                    pm_ready <= 1'b1;
                    pm_rdata <= pm_mem[pm_addr[9:2]];
                    if (pm_rw) pm_mem[pm_addr[9:2]] <= pm_wdata;
                end
            end else pm_wait <= pm_wait + 1;
        end
    end

    always @(posedge clk) begin
        dm_ready <= 1'b0;
        dm_oor   <= 1'b0;
        if (dm_valid && !dm_ready && !dm_oor) begin
            if (dm_wait >= mem_lat) begin
                dm_wait <= 0;
                if (dm_addr >= MEM_BYTES) dm_oor <= 1'b1;
                else begin
                    dm_ready <= 1'b1;
                    dm_rdata <= dm_mem[dm_addr[9:2]];
                    if (dm_rw) dm_mem[dm_addr[9:2]] <= dm_wdata;
                end
            end else dm_wait <= dm_wait + 1;
        end
    end

    // Register file writes plus a core that understands three one-instruction programs
    always @(posedge clk) begin
        if (rf_do_wb) begin
            if (rf_wb_fp) fp_rf[rf_wb_add] <= rf_wb_data;
            else int_rf[rf_wb_add] <= rf_wb_data;
            if (!rf_wb_fp && rf_wb_add == 5'd0) x0_wb_cnt <= x0_wb_cnt + 1;
        end
        if (core_rst || !core_start) begin
            running    <= 1'b0;
            core_ready <= 1'b0;
            run_cnt    <= 0;
        end else if (!running) begin
            running   <= 1'b1;
            run_cnt   <= 0;
            prog_word <= pm_mem[core_init_pc[9:2]];
            core_pc   <= core_init_pc;
        end else if (!core_ready) begin
            run_cnt <= run_cnt + 1;
            if (prog_word == ADDI_A0_7 && run_cnt == fin_cnt) begin
                core_ready <= 1'b1;
                core_exit  <= 2'b00;
                core_pc    <= core_init_pc + 32'd4;
                int_rf[10] <= 32'd7;
            end else if (prog_word == EBREAK) begin
                core_ready <= 1'b1;
                core_exit  <= 2'b01;
            end
        end
    end

    // ---------------- checking ----------------
    typedef struct {
        int          tag;
        logic [31:0] data;
        logic [2:0]  status;
    } exp_t;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp_data;
        logic [2:0]  exp_status;
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   core_rst_cycles = 0;
    int   rst_overlap = 0;
    int   sel_err = 0;
    int   rsp_valid_cycles = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Scoreboard pop on each completed response handshake, plus protocol monitors
    always @(negedge clk) begin
        if (!rst) begin
            if (rsp_valid) rsp_valid_cycles++;
            if (core_rst) core_rst_cycles++;
            if (core_rst && core_start) rst_overlap++;
            if ((pm_valid && !pm_sel) || (dm_valid && !dm_sel) || (rf_do_wb && !rf_sel)) sel_err++;
            if (core_start && (pm_sel || dm_sel || rf_sel)) sel_err++;
            if (rsp_valid && rsp_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp: got data 0x%08h status %03b, none required", rsp_data, rsp_status);
                end else begin
                    mon_e = sb.pop_front();
                    check($sformatf("rsp_data[%0d]", mon_e.tag), rsp_data, mon_e.data);
                    check($sformatf("rsp_status[%0d]", mon_e.tag), {29'd0, rsp_status}, {29'd0, mon_e.status});
                end
            end
        end
    end

    task automatic drive_cmd(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] data);
        int n;
        @(negedge clk);
        n = 0;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("cmd_ready_wait", {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = addr;
        cmd_data  = data;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_sb_empty();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL rsp_timeout: got %0d pending responses, required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic send_cmd(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] data,
                            input logic [31:0] exp_data, input logic [2:0] exp_status, input int tag);
        sb.push_back('{tag, exp_data, exp_status});
        drive_cmd(op, addr, data);
        wait_sb_empty();
    endtask

    vec_t vecs[23];
    int   rv_before;

    initial begin
        vecs[0]  = '{3'd0, 32'h0000_0000, 32'h0000_0013, 32'h0000_0000, 3'b000};
        vecs[1]  = '{3'd1, 32'h0000_0000, 32'h0000_0000, 32'h0000_0013, 3'b000};
        vecs[2]  = '{3'd2, 32'h0000_0040, 32'hCAFE_F00D, 32'h0000_0000, 3'b000};
        vecs[3]  = '{3'd3, 32'h0000_0040, 32'h0000_0000, 32'hCAFE_F00D, 3'b000};
        vecs[4]  = '{3'd1, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0000, 3'b001};
        vecs[5]  = '{3'd2, 32'h0000_1000, 32'h1234_5678, 32'h0000_0000, 3'b001};
        vecs[6]  = '{3'd5, 32'h0000_0005, 32'hDEAD_BEEF, 32'h0000_0000, 3'b000};
        vecs[7]  = '{3'd5, 32'h0000_0025, 32'h3F80_0000, 32'h0000_0000, 3'b000};
        vecs[8]  = '{3'd5, 32'h0000_0000, 32'h0000_0001, 32'h0000_0000, 3'b000};
        vecs[9]  = '{3'd5, 32'h0000_0020, 32'h0000_0011, 32'h0000_0000, 3'b000};
        vecs[10] = '{3'd4, 32'h0000_0005, 32'h0000_0000, 32'hDEAD_BEEF, 3'b000};
        vecs[11] = '{3'd4, 32'h0000_0025, 32'h0000_0000, 32'h3F80_0000, 3'b000};
        vecs[12] = '{3'd4, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 3'b000};
        vecs[13] = '{3'd4, 32'h0000_0020, 32'h0000_0000, 32'h0000_0011, 3'b000};
        vecs[14] = '{3'd4, 32'h0000_0045, 32'h0000_0000, 32'hDEAD_BEEF, 3'b000};
        vecs[15] = '{3'd7, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 3'b010};
        vecs[16] = '{3'd0, 32'h0000_0000, ADDI_A0_7,     32'h0000_0000, 3'b000};
        vecs[17] = '{3'd0, 32'h0000_0004, ECALL,         32'h0000_0000, 3'b000};
        vecs[18] = '{3'd0, 32'h0000_0008, EBREAK,        32'h0000_0000, 3'b000};
        vecs[19] = '{3'd6, 32'h0000_0000, 32'h0000_0000, 32'h0000_0004, 3'b100};
        vecs[20] = '{3'd4, 32'h0000_000A, 32'h0000_0000, 32'h0000_0007, 3'b000};
        vecs[21] = '{3'd6, 32'h0000_0000, 32'h0000_0008, 32'h0000_0008, 3'b101};
        vecs[22] = '{3'd3, 32'h0000_0040, 32'h0000_0000, 32'hCAFE_F00D, 3'b000};

        repeat (3) @(negedge clk);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_core_start", {31'd0, core_start}, 32'd0);
        check("rst_pm_valid", {31'd0, pm_valid}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_run_cycles", run_cycles, 32'd0);
        check("rst_rsp_data", rsp_data, 32'd0);
        check("idle_cmd_ready", {31'd0, cmd_ready}, 32'd1);

        for (int i = 0; i < 23; i++) begin
            mem_lat = i % 3;
            send_cmd(vecs[i].op, vecs[i].addr, vecs[i].data, vecs[i].exp_data, vecs[i].exp_status, i);
        end
        check("ebreak_run_cycles", run_cycles, 32'd2);
        check("x0_write_strobes", x0_wb_cnt, 32'd0);
        check("post_pm_valid", {31'd0, pm_valid}, 32'd0);
        check("post_dm_valid", {31'd0, dm_valid}, 32'd0);
        check("post_core_start", {31'd0, core_start}, 32'd0);
        check("post_cmd_ready", {31'd0, cmd_ready}, 32'd1);

        // timeout on a self-loop, then the ecall program again
        send_cmd(3'd0, 32'h0000_0100, JAL_SELF, 32'h0, 3'b000, 100);
        send_cmd(3'd6, 32'h0, 32'h0000_0100, 32'h0000_0100, 3'b011, 101);
        check("timeout_run_cycles", run_cycles, 32'd100);
        check("core_rst_cycles", core_rst_cycles, 32'd1);
        check("core_rst_vs_start", rst_overlap, 32'd0);
        send_cmd(3'd6, 32'h0, 32'h0, 32'h0000_0004, 3'b100, 102);
        check("rerun_run_cycles", run_cycles, 32'd7);

        // core_ready arrives in the very cycle run_cycles reaches the limit
        fin_cnt = 98;
        send_cmd(3'd6, 32'h0, 32'h0, 32'h0000_0004, 3'b100, 103);
        check("race_run_cycles", run_cycles, 32'd100);
        check("race_no_abort", core_rst_cycles, 32'd1);
        fin_cnt = 5;

        // response held while rsp_ready is low
        rsp_ready = 1'b0;
        sb.push_back('{104, 32'h0, 3'b010});
        drive_cmd(3'd7, 32'h0, 32'h0);
        for (int n = 0; n < 20 && !rsp_valid; n++) @(negedge clk);
        for (int n = 0; n < 5; n++) begin
            check("stall_valid", {31'd0, rsp_valid}, 32'd1);
            check("stall_status", {29'd0, rsp_status}, 32'd2);
            check("stall_cmd_ready", {31'd0, cmd_ready}, 32'd0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        wait_sb_empty();

        // asynchronous reset in the middle of a run drops the command silently
        drive_cmd(3'd6, 32'h0, 32'h0000_0100);
        repeat (10) @(negedge clk);
        check("run_core_start", {31'd0, core_start}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_core_start", {31'd0, core_start}, 32'd0);
        check("rst_mid_run_cycles", run_cycles, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        rv_before = rsp_valid_cycles;
        repeat (20) @(negedge clk);
        check("rst_mid_no_rsp", rsp_valid_cycles, rv_before);
        send_cmd(3'd1, 32'h0, 32'h0, ADDI_A0_7, 3'b000, 105);
        check("sel_violations", sel_err, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
